dffram_port_arbiter: RTL and testbench

- Shares one single-port DFFRAM256x32 macro between two independent requesters: port 0 (AHB-Lite wrapper side) and port 1 (DMA/accelerator side).
- Each port uses a simple req/gnt handshake. The arbiter drives the macro's EN0/WE0/A0/Di0 pins and returns Do0 read data, with rvalid, to the port that issued the read.
- Round-robin arbitration with a burst cap, so neither port starves the other.
- Sits between the bus-side SRAM interfaces and the DFFRAM256x32 instance, all on HCLK.

---
 rtl/dffram_port_arbiter.sv | 172 +++++++++++++++++
 tb/tb_dffram_port_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dffram_port_arbiter.sv
// Two-port arbiter in front of a single-port DFFRAM256x32 macro: round-robin with burst cap,
// 1-cycle read return. Define DFFRAM_ARB_FIXED_PRIO_EN for strict port-0 priority instead.
module dffram_port_arbiter #(
    parameter int AW        = 8,
    parameter int MAX_BURST = 4
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic          p0_req,
    input  logic [3:0]    p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [31:0]   p0_wdata,
    output logic          p0_gnt,
    output logic          p0_rvalid,
    output logic [31:0]   p0_rdata,
    input  logic          p1_req,
    input  logic [3:0]    p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [31:0]   p1_wdata,
    output logic          p1_gnt,
    output logic          p1_rvalid,
    output logic [31:0]   p1_rdata,
    output logic          ram_en,
    output logic [3:0]    ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [31:0]   ram_wdata,
    input  logic [31:0]   ram_rdata
);

    logic        gnt0_s;
    logic        gnt1_s;
    logic        g0_s;
    logic        g1_s;
    logic        tag_valid_q;
    logic        tag_valid_d;
    logic        tag_port_q;
    logic        tag_port_d;
    logic [31:0] p0_rdata_q;
    logic [31:0] p1_rdata_q;

`ifdef DFFRAM_ARB_FIXED_PRIO_EN

    // Strict priority: port 1 only sees the macro when port 0 is idle.
    always_comb begin
        gnt0_s = p0_req;
        gnt1_s = p1_req & ~p0_req;
    end

`else

    localparam logic [3:0] BURST_CAP = 4'(MAX_BURST);

    logic       last_q;
    logic       last_d;
    logic [3:0] cnt_q;
    logic [3:0] cnt_d;
    logic       p0_req_q;
    logic       p1_req_q;
    logic       keep_s;
    logic       win1_s;

    // Tie-break: the last winner may extend its burst only against a newly arriving
    // requester; once the other port has been waiting a cycle, the grant alternates.
    always_comb begin
        keep_s = 1'b0;
        win1_s = 1'b0;
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (p0_req && p1_req) begin
            if (last_q) begin
                keep_s = !p0_req_q && (cnt_q != 4'd0) && (cnt_q < BURST_CAP);
            end else begin
                keep_s = !p1_req_q && (cnt_q != 4'd0) && (cnt_q < BURST_CAP);
            end
            win1_s = keep_s ? last_q : !last_q;
            gnt0_s = !win1_s;
            gnt1_s = win1_s;
        end else begin
            gnt0_s = p0_req;
            gnt1_s = p1_req;
        end
    end

    // Pointer and burst counter; the counter saturates so a lone requester is never capped.
    always_comb begin
        last_d = last_q;
        cnt_d  = cnt_q;
        if (gnt0_s || gnt1_s) begin
            if (gnt1_s != last_q) begin
                last_d = gnt1_s;
                cnt_d  = 4'd1;
            end else if (cnt_q < BURST_CAP) begin
                cnt_d  = cnt_q + 4'd1;
            end else begin
                cnt_d  = cnt_q;
            end
        end else begin
            last_d = last_q;
            cnt_d  = cnt_q;
        end
    end

    // Arbitration state registers.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            last_q   <= 1'b1;
            cnt_q    <= 4'd0;
            p0_req_q <= 1'b0;
            p1_req_q <= 1'b0;
        end else begin
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            p0_req_q <= p0_req;
            p1_req_q <= p1_req;
        end
    end

`endif

    assign g0_s   = gnt0_s & HRESETn;
    assign g1_s   = gnt1_s & HRESETn;
    assign p0_gnt = g0_s;
    assign p1_gnt = g1_s;
    assign ram_en = g0_s | g1_s;

    // Macro pin mux from the granted port; all-zero when nothing is granted.
    always_comb begin
        ram_we    = 4'b0000;
        ram_addr  = '0;
        ram_wdata = 32'h0000_0000;
        if (g0_s) begin
            ram_we    = p0_we;
            ram_addr  = p0_addr;
            ram_wdata = p0_wdata;
        end else if (g1_s) begin
            ram_we    = p1_we;
            ram_addr  = p1_addr;
            ram_wdata = p1_wdata;
        end else begin
            ram_we    = 4'b0000;
            ram_addr  = '0;
            ram_wdata = 32'h0000_0000;
        end
    end

    // Read tag for the access accepted this cycle.
    always_comb begin
        tag_valid_d = (gnt0_s && (p0_we == 4'b0000)) || (gnt1_s && (p1_we == 4'b0000));
        tag_port_d  = gnt1_s;
    end

    assign p0_rvalid = tag_valid_q & ~tag_port_q;
    assign p1_rvalid = tag_valid_q &  tag_port_q;
    assign p0_rdata  = p0_rvalid ? ram_rdata : p0_rdata_q;
    assign p1_rdata  = p1_rvalid ? ram_rdata : p1_rdata_q;

    // Read tag and per-port held read data.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            tag_valid_q <= 1'b0;
            tag_port_q  <= 1'b0;
            p0_rdata_q  <= 32'h0000_0000;
            p1_rdata_q  <= 32'h0000_0000;
        end else begin
            tag_valid_q <= tag_valid_d;
            tag_port_q  <= tag_port_d;
            p0_rdata_q  <= p0_rdata;
            p1_rdata_q  <= p1_rdata;
        end
    end

endmodule

// File: tb/tb_dffram_port_arbiter.sv
// Directed self-checking bench for dffram_port_arbiter with a behavioural DFFRAM256x32 model.
module tb_dffram_port_arbiter;

    localparam int AW = 8;

    logic          HCLK = 1'b0;
    logic          HRESETn = 1'b0;
    logic          p0_req = 1'b0, p1_req = 1'b0;
    logic [3:0]    p0_we = 4'b0000, p1_we = 4'b0000;
    logic [AW-1:0] p0_addr = 8'h00, p1_addr = 8'h00;
    logic [31:0]   p0_wdata = 32'h0, p1_wdata = 32'h0;
    logic          p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
    logic [31:0]   p0_rdata, p1_rdata;
    logic          ram_en;
    logic [3:0]    ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic s_g0, s_g1, s_en, s_rv0, s_rv1;
    logic [3:0]    s_we;
    logic [AW-1:0] s_addr;
    logic [31:0]   s_wdata, s_rd0, s_rd1;

    dffram_port_arbiter #(.AW(AW), .MAX_BURST(4)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    always #5 HCLK = ~HCLK;

    // Macro model: unwritten words read as a known address-derived pattern.
    logic [31:0]  mem [0:255];
    logic [255:0] wr_v = '0;
    logic [31:0]  cur;

    function automatic logic [31:0] init_val(input logic [7:0] a);
        if (a == 8'h30) return 32'h1122_3344;
        return 32'hA000_0000 | {24'h0, a};
    endfunction

    always @(posedge HCLK) begin
        if (ram_en) begin
            cur = wr_v[ram_addr] ? mem[ram_addr] : init_val(ram_addr);
            if (ram_we == 4'b0000) begin
                ram_rdata <= cur;
            end else begin
                for (int b = 0; b < 4; b++)
                    if (ram_we[b]) cur[8*b +: 8] = ram_wdata[8*b +: 8];
                mem[ram_addr] = cur;
                wr_v[ram_addr] = 1'b1;
            end
        end
    end

    // One clock: grant-side signals sampled mid-cycle, response side just after the edge.
    task automatic tick();
        #3;
        s_g0 = p0_gnt; s_g1 = p1_gnt; s_en = ram_en; s_we = ram_we;
        s_addr = ram_addr; s_wdata = ram_wdata;
        @(posedge HCLK);
        #1;
        s_rv0 = p0_rvalid; s_rv1 = p1_rvalid; s_rd0 = p0_rdata; s_rd1 = p1_rdata;
    endtask

    task automatic idle();
        p0_req = 1'b0; p1_req = 1'b0; p0_we = 4'b0000; p1_we = 4'b0000;
    endtask

    task automatic do_reset();
        idle();
        HRESETn = 1'b0;
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
    endtask

    task automatic test_reset();
        HRESETn = 1'b0;
        p0_req = 1'b1; p1_req = 1'b1;
        #2;
        total_cnt++;
        if ({p0_gnt, p1_gnt, ram_en} !== 3'b000)
            $display("FAIL reset_gnt got=%b exp=000", {p0_gnt, p1_gnt, ram_en});
        else pass_cnt++;
        idle();
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            total_cnt++;
            if ({s_g0, s_g1, s_en, s_we, s_addr, s_wdata, s_rv0, s_rv1, s_rd0, s_rd1} !== '0)
                $display("FAIL reset_idle cyc=%0d got g=%b%b en=%b rv=%b%b rd0=%h rd1=%h exp all 0",
                         i, s_g0, s_g1, s_en, s_rv0, s_rv1, s_rd0, s_rd1);
            else pass_cnt++;
        end
    endtask

    task automatic test_write_read();
        p0_req = 1'b1; p0_we = 4'b1111; p0_addr = 8'h12; p0_wdata = 32'hDEAD_BEEF;
        tick();
        total_cnt++;
        if ({s_g0, s_g1} !== 2'b10) $display("FAIL wr_gnt got=%b exp=10", {s_g0, s_g1});
        else pass_cnt++;
        total_cnt++;
        if ({s_en, s_we, s_addr, s_wdata} !== {1'b1, 4'b1111, 8'h12, 32'hDEAD_BEEF})
            $display("FAIL wr_macro got en=%b we=%b a=%h d=%h exp 1 1111 12 deadbeef",
                     s_en, s_we, s_addr, s_wdata);
        else pass_cnt++;
        total_cnt++;
        if ({s_rv0, s_rv1} !== 2'b00) $display("FAIL wr_no_rvalid got=%b exp=00", {s_rv0, s_rv1});
        else pass_cnt++;
        p0_req = 1'b0; p0_we = 4'b0000;
        p1_req = 1'b1; p1_we = 4'b0000; p1_addr = 8'h12;
        tick();
        total_cnt++;
        if ({s_g0, s_g1, s_we} !== {2'b01, 4'b0000}) $display("FAIL rd_gnt got=%b exp=010000", {s_g0, s_g1, s_we});
        else pass_cnt++;
        total_cnt++;
        if ({s_rv0, s_rv1, s_rd1} !== {2'b01, 32'hDEAD_BEEF})
            $display("FAIL rd_data got rv=%b%b rd1=%h exp 01 deadbeef", s_rv0, s_rv1, s_rd1);
        else pass_cnt++;
        idle();
        tick();
        total_cnt++;
        if ({s_en, s_rv0, s_rv1, s_rd1} !== {3'b000, 32'hDEAD_BEEF})
            $display("FAIL rd_hold got en=%b rv=%b%b rd1=%h exp 000 deadbeef", s_en, s_rv0, s_rv1, s_rd1);
        else pass_cnt++;
    endtask

    task automatic test_alternate();
        logic [7:0]  i0, i1;
        logic        exp1;
        logic [31:0] exp_d;
        do_reset();
        i0 = 8'h20; i1 = 8'h40;
        p0_req = 1'b1; p1_req = 1'b1;
        for (int k = 0; k < 8; k++) begin
            p0_addr = i0; p1_addr = i1;
            exp1 = (k % 2 == 1);
            exp_d = 32'hA000_0000 | {24'h0, (exp1 ? i1 : i0)};
            tick();
            total_cnt++;
            if ({s_g0, s_g1} !== {~exp1, exp1})
                $display("FAIL alt_gnt cyc=%0d got=%b exp=%b", k, {s_g0, s_g1}, {~exp1, exp1});
            else pass_cnt++;
            total_cnt++;
            if ({s_rv0, s_rv1} !== {~exp1, exp1} || (exp1 ? s_rd1 : s_rd0) !== exp_d)
                $display("FAIL alt_rd cyc=%0d got rv=%b%b rd0=%h rd1=%h exp port%0d %h",
                         k, s_rv0, s_rv1, s_rd0, s_rd1, exp1, exp_d);
            else pass_cnt++;
            if (exp1) i1 = i1 + 8'd1; else i0 = i0 + 8'd1;
        end
        idle();
    endtask

    task automatic test_burst_cap();
        do_reset();
        p0_req = 1'b1; p0_addr = 8'h50;
        for (int k = 0; k < 3; k++) begin
            tick();
            total_cnt++;
            if ({s_g0, s_g1} !== 2'b10) $display("FAIL burst_solo cyc=%0d got=%b exp=10", k, {s_g0, s_g1});
            else pass_cnt++;
        end
        p1_req = 1'b1; p1_addr = 8'h60;
        tick();
        total_cnt++;
        if ({s_g0, s_g1} !== 2'b10) $display("FAIL burst_4th got=%b exp=10", {s_g0, s_g1});
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({s_g0, s_g1, s_rv1, s_rd1} !== {3'b011, 32'hA000_0060})
            $display("FAIL burst_switch got g=%b rv1=%b rd1=%h exp 01 1 a0000060", {s_g0, s_g1}, s_rv1, s_rd1);
        else pass_cnt++;
        p1_req = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        total_cnt++;
        if ({s_g0, s_g1} !== 2'b10) $display("FAIL burst_long_solo got=%b exp=10", {s_g0, s_g1});
        else pass_cnt++;
        p1_req = 1'b1;
        tick();
        total_cnt++;
        if ({s_g0, s_g1} !== 2'b01) $display("FAIL burst_saturated got=%b exp=01", {s_g0, s_g1});
        else pass_cnt++;
        idle();
    endtask

    task automatic test_fixed_prio();
        do_reset();
        p0_req = 1'b1; p1_req = 1'b1; p0_addr = 8'h21; p1_addr = 8'h41;
        for (int k = 0; k < 8; k++) begin
            tick();
            total_cnt++;
            if ({s_g0, s_g1} !== 2'b10) $display("FAIL prio_gnt cyc=%0d got=%b exp=10", k, {s_g0, s_g1});
            else pass_cnt++;
        end
        p0_req = 1'b0;
        tick();
        total_cnt++;
        if ({s_g0, s_g1} !== 2'b01) $display("FAIL prio_p1 got=%b exp=01", {s_g0, s_g1});
        else pass_cnt++;
        idle();
    endtask

    task automatic test_byte_write();
        p0_req = 1'b1; p0_we = 4'b0100; p0_addr = 8'h30; p0_wdata = 32'h00AB_0000;
        tick();
        total_cnt++;
        if ({s_g0, s_en, s_we} !== {2'b11, 4'b0100}) $display("FAIL bw_gnt got=%b exp=110100", {s_g0, s_en, s_we});
        else pass_cnt++;
        p0_req = 1'b0; p0_we = 4'b0000;
        p1_req = 1'b1; p1_we = 4'b0000; p1_addr = 8'h30;
        tick();
        total_cnt++;
        if ({s_rv1, s_rd1} !== {1'b1, 32'h11AB_3344})
            $display("FAIL bw_raw_p1 got rv1=%b rd1=%h exp 1 11ab3344", s_rv1, s_rd1);
        else pass_cnt++;
        p1_req = 1'b0;
        p0_req = 1'b1; p0_addr = 8'h30;
        tick();
        total_cnt++;
        if ({s_rv0, s_rv1, s_rd0} !== {2'b10, 32'h11AB_3344})
            $display("FAIL bw_rd_p0 got rv=%b%b rd0=%h exp 10 11ab3344", s_rv0, s_rv1, s_rd0);
        else pass_cnt++;
        idle();
    endtask

    task automatic test_reset_mid();
        logic seen_rv;
        p1_req = 1'b1; p1_we = 4'b0000; p1_addr = 8'h41;
        #3;
        total_cnt++;
        if (p1_gnt !== 1'b1) $display("FAIL rm_gnt got=%b exp=1", p1_gnt);
        else pass_cnt++;
        @(posedge HCLK);
        HRESETn = 1'b0;
        seen_rv = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            seen_rv = seen_rv | p1_rvalid;
        end
        total_cnt++;
        if ({p1_gnt, p1_rvalid} !== 2'b00) $display("FAIL rm_gnt_drop got=%b exp=00", {p1_gnt, p1_rvalid});
        else pass_cnt++;
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        seen_rv = seen_rv | p1_rvalid;
        p0_req = 1'b1; p0_we = 4'b0000; p0_addr = 8'h22;
        tick();
        seen_rv = seen_rv | s_rv1;
        total_cnt++;
        if (seen_rv !== 1'b0) $display("FAIL rm_no_rvalid got=%b exp=0", seen_rv);
        else pass_cnt++;
        total_cnt++;
        if ({s_g0, s_g1, s_rv0, s_rd0} !== {3'b101, 32'hA000_0022})
            $display("FAIL rm_first_tie got g=%b rv0=%b rd0=%h exp 10 1 a0000022", {s_g0, s_g1}, s_rv0, s_rd0);
        else pass_cnt++;
        idle();
        tick();
    endtask

    initial begin
        test_reset();
        test_write_read();
`ifdef DFFRAM_ARB_FIXED_PRIO_EN
        test_fixed_prio();
`else
        test_alternate();
        test_burst_cap();
`endif
        test_byte_write();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
